// File: rtl/fir_out_requant_decim.sv
// FIR output conditioning: warm-up discard, decimation, Q30->Q15
// round/saturate, and a small output FIFO with sticky status flags.
module fir_out_requant_decim #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 2,
  parameter int WARMUP     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  input  logic                          clear_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [0:0] S_WARM = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [0:0] S_INIT = (WARMUP == 0) ? S_RUN : S_WARM;

  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_SAT = ~POS_SAT;

  logic [0:0]    r_state;
  logic [CW-1:0] r_wcnt;
  logic [PW-1:0] r_phase;
  logic          w_keep;

  assign w_keep = in_valid && (r_state == S_RUN) && (r_phase == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_wcnt  <= '0;
      r_phase <= '0;
    end else if (in_valid) begin
      if (r_state == S_WARM) begin
        if (r_wcnt == CW'(WARMUP - 1)) begin
          r_state <= S_RUN;
          r_wcnt  <= '0;
        end else begin
          r_wcnt <= r_wcnt + CW'(1);
        end
      end else begin
        r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
      end
    end
  end

  // one extra bit keeps the half-up rounding add from wrapping
  logic signed [IN_W:0] w_s1_sum;
  logic signed [IN_W:0] r_s1_d;
  logic                 r_s1_v;

  assign w_s1_sum = $signed({in_data[IN_W-1], in_data}) + RND;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v <= 1'b0;
      r_s1_d <= '0;
    end else begin
      r_s1_v <= w_keep;
      r_s1_d <= w_s1_sum >>> SHIFT;
    end
  end

  logic             w_hi;
  logic             w_lo;
  logic             w_sat;
  logic [OUT_W-1:0] w_s2_d;
  logic [OUT_W-1:0] r_s2_d;
  logic             r_s2_v;

  assign w_hi   = r_s1_d > MAXV;
  assign w_lo   = r_s1_d < MINV;
  assign w_sat  = r_s1_v && (w_hi || w_lo);
  assign w_s2_d = w_hi ? POS_SAT :
                  w_lo ? NEG_SAT : r_s1_d[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_v <= 1'b0;
      r_s2_d <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      r_s2_d <= w_s2_d;
    end
  end

  logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && out_ready;
  // a full FIFO still accepts a push when the head leaves the same cycle
  assign w_push  = r_s2_v && (!w_full || w_pop);
  assign w_drop  = r_s2_v && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_s2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  logic r_sat;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sat <= w_sat  | (r_sat & ~clear_flags);
      r_ovf <= w_drop | (r_ovf & ~clear_flags);
    end
  end

  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign fifo_level = w_level;
  assign sat_flag   = r_sat;
  assign ovf_flag   = r_ovf;

endmodule

// File: tb/tb_fir_out_requant_decim.sv
// Bench for fir_out_requant_decim: two instances (warm-up/DECIM=1 and
// no-warm-up/DECIM=3) against a sample-index model plus literal checks.
module tb_fir_out_requant_decim;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        clear_flags = 1'b0;

  logic        ov  [2];
  logic [15:0] od  [2];
  logic [3:0]  lvl [2];
  logic        sf  [2];
  logic        of  [2];

  fir_out_requant_decim #(.WARMUP(20), .DECIM(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .fifo_level(lvl[0]), .sat_flag(sf[0]), .ovf_flag(of[0]),
    .clear_flags(clear_flags)
  );

  fir_out_requant_decim #(.WARMUP(0), .DECIM(3)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .fifo_level(lvl[1]), .sat_flag(sf[1]), .ovf_flag(of[1]),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // round half-up then clamp, returned as {clipped, q15}
  function automatic logic [16:0] quant(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + 16384) >>> 15;
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  int          m_wu [2] = '{20, 0};
  int          m_dc [2] = '{1, 3};
  int          m_seen [2];
  bit          m_p0v [2];
  bit          m_p0s [2];
  bit          m_p1v [2];
  logic [15:0] m_p0d [2];
  logic [15:0] m_p1d [2];
  int          m_len [2];
  logic [15:0] m_q [2][8];
  bit          m_sat [2];
  bit          m_ovf [2];

  logic [15:0] popa [$];
  logic [15:0] popc [$];
  bit          started = 0;
  bit          rose = 0;
  int          rise_cyc = -1;

  initial begin
    bit          pop, ovf_ev, sat_ev, keep;
    logic [16:0] qv;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("out_valid[%0d]", k), 64'(ov[k]),
                64'(m_len[k] > 0));
          check($sformatf("out_data[%0d]", k), 64'(od[k]),
                64'((m_len[k] > 0) ? m_q[k][0] : 16'h0));
          check($sformatf("fifo_level[%0d]", k), 64'(lvl[k]),
                64'(m_len[k]));
          check($sformatf("sat_flag[%0d]", k), 64'(sf[k]), 64'(m_sat[k]));
          check($sformatf("ovf_flag[%0d]", k), 64'(of[k]), 64'(m_ovf[k]));
        end
        if (!rose && ov[0]) begin
          rose = 1;
          rise_cyc = cyc;
        end
      end
      if (!reset && out_ready) begin
        if (ov[0]) popa.push_back(od[0]);
        if (ov[1]) popc.push_back(od[1]);
      end
      // advance the model across the coming rising edge
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          m_seen[k] = 0;
          m_p0v[k] = 0;
          m_p1v[k] = 0;
          m_len[k] = 0;
          m_sat[k] = 0;
          m_ovf[k] = 0;
        end else begin
          pop = (m_len[k] > 0) && out_ready;
          if (pop) begin
            for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
            m_len[k]--;
          end
          ovf_ev = 0;
          if (m_p1v[k]) begin
            if (m_len[k] < 8) begin
              m_q[k][m_len[k]] = m_p1d[k];
              m_len[k]++;
            end else begin
              ovf_ev = 1;
            end
          end
          sat_ev = m_p0v[k] && m_p0s[k];
          m_sat[k] = sat_ev || (m_sat[k] && !clear_flags);
          m_ovf[k] = ovf_ev || (m_ovf[k] && !clear_flags);
          m_p1v[k] = m_p0v[k];
          m_p1d[k] = m_p0d[k];
          keep = in_valid && (m_seen[k] >= m_wu[k]) &&
                 ((m_seen[k] - m_wu[k]) % m_dc[k] == 0);
          qv = quant(in_data);
          m_p0v[k] = keep;
          m_p0s[k] = qv[16];
          m_p0d[k] = qv[15:0];
          if (in_valid) m_seen[k]++;
        end
      end
      if (reset) started = 1;
    end
  end

  task automatic step(input bit v, input logic [31:0] d,
                      input bit clr = 0);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data = d;
    clear_flags = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 32'h0);
  endtask

  logic [31:0] vin  [5] = '{32'h0000_4000, 32'hFFFF_C000, 32'hFFFF_BFFF,
                            32'h4000_0000, 32'h8000_0000};
  logic [15:0] vexp [5] = '{16'h0001, 16'h0000, 16'hFFFF,
                            16'h7FFF, 16'h8000};
  int c20;

  initial begin
    idle(3);
    reset = 0;
    check("rst_valid", 64'(ov[0]), 64'd0);
    check("rst_data", 64'(od[0]), 64'd0);
    check("rst_level", 64'(lvl[0]), 64'd0);
    check("rst_flags", 64'({sf[0], of[0]}), 64'd0);

    // warm-up discard on u_a, decimation with a gap on u_c
    for (int i = 0; i <= 20; i++) begin
      step(1, 32'(i) * 32'h8000);
      if (i == 20) c20 = cyc;
      if (i == 4) idle(5);
    end
    idle(8);
    check("warm_latency", 64'(rise_cyc), 64'(c20 + 3));
    check("warm_count", 64'(popa.size()), 64'd1);
    check("warm_first", 64'(popa[0]), 64'd20);
    check("decim_count", 64'(popc.size()), 64'd7);
    check("decim_0", 64'(popc[0]), 64'd0);
    check("decim_1", 64'(popc[1]), 64'd3);
    check("decim_2", 64'(popc[2]), 64'd6);

    // rounding and saturation
    popa.delete();
    for (int i = 0; i < 5; i++) step(1, vin[i]);
    idle(6);
    check("round_count", 64'(popa.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("round_%0d", i), 64'(popa[i]), 64'(vexp[i]));
    check("sat_set", 64'(sf[0]), 64'd1);
    step(0, 32'h0, 1);
    step(0, 32'h0);
    check("sat_clear", 64'(sf[0]), 64'd0);
    step(1, 32'h4000_0000);
    step(0, 32'h0, 1);
    step(0, 32'h0);
    check("sat_set_wins", 64'(sf[0]), 64'd1);
    idle(4);
    step(0, 32'h0, 1);
    step(0, 32'h0);
    check("flags_clear", 64'({sf[0], of[0]}), 64'd0);

    // backpressure and overflow
    popa.delete();
    out_ready = 0;
    for (int i = 1; i <= 10; i++) step(1, 32'(i) * 32'h8000);
    idle(6);
    check("ovf_level", 64'(lvl[0]), 64'd8);
    check("ovf_flag", 64'(of[0]), 64'd1);
    check("ovf_head", 64'(od[0]), 64'd1);
    out_ready = 1;
    idle(12);
    check("ovf_count", 64'(popa.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("ovf_order_%0d", i), 64'(popa[i]), 64'(i + 1));
    step(0, 32'h0, 1);
    step(0, 32'h0);

    // full FIFO with simultaneous push and pop
    popa.delete();
    out_ready = 0;
    for (int i = 0; i < 8; i++) step(1, 32'(101 + i) * 32'h8000);
    idle(4);
    check("full_level", 64'(lvl[0]), 64'd8);
    for (int i = 8; i < 20; i++) begin
      step(1, 32'(101 + i) * 32'h8000);
      if (i == 10) out_ready = 1;
      if (i > 10) check($sformatf("pp_level_%0d", i), 64'(lvl[0]), 64'd8);
    end
    check("pp_no_ovf", 64'(of[0]), 64'd0);
    idle(12);
    check("pp_count", 64'(popa.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      check($sformatf("pp_order_%0d", i), 64'(popa[i]), 64'(101 + i));

    // reset with words queued, then warm-up again
    popa.delete();
    out_ready = 0;
    for (int i = 0; i < 5; i++) step(1, 32'(200 + i) * 32'h8000);
    idle(4);
    check("pre_rst_level", 64'(lvl[0]), 64'd5);
    step(0, 32'h0);
    reset = 1;
    step(0, 32'h0);
    reset = 0;
    check("mid_rst_valid", 64'(ov[0]), 64'd0);
    check("mid_rst_level", 64'(lvl[0]), 64'd0);
    out_ready = 1;
    for (int i = 0; i <= 20; i++) step(1, 32'(300 + i) * 32'h8000);
    idle(6);
    check("rewarm_count", 64'(popa.size()), 64'd1);
    check("rewarm_first", 64'(popa[0]), 64'd320);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_out_requant_decim.md
Name: fir_out_requant_decim

Overview:
Output conditioning stage placed directly after the 16-tap Chebyshev FIR. It takes the FIR's 32-bit Q30 accumulator result and discards the pipeline warm-up samples. It then decimates by an integer factor, rounds and saturates each kept sample to 16-bit Q15, and buffers the results in a small FIFO behind a valid/ready output handshake. Sticky status flags report saturation and FIFO overflow.

Parameters:
IN_W, 32, input sample width (FIR accumulator output, Q30 signed)
OUT_W, 16, output sample width (signed)
SHIFT, 15, arithmetic right shift applied after rounding (Q30 -> Q15); must be >= 1
DECIM, 2, decimation factor, 1..16; 1 = keep every sample
WARMUP, 20, number of accepted input samples discarded after reset (covers the FIR fill plus multiplier/adder-tree latency); 0 allowed
FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  in_data carries a FIR output sample this cycle
in_data  in  IN_W  signed FIR output sample
out_valid  out  1  out_data holds a FIFO head sample
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  OUT_W  signed Q15 sample (FIFO head)
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
sat_flag  out  1  sticky: at least one kept sample was clipped
ovf_flag  out  1  sticky: at least one sample was dropped because the FIFO was full
clear_flags  in  1  single-cycle pulse; clears sat_flag and ovf_flag

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values:
  - out_valid=0, out_data=0, fifo_level=0, sat_flag=0, ovf_flag=0.
  - Pipeline valids are cleared; FIFO pointers are 0.
  - State is WARMUP (RUN if WARMUP==0); decimation phase is 0.
- Reset mid-operation flushes all pipeline and FIFO contents; no partial sample is emitted afterwards.
- State machine, two states:
  - WARMUP: a counter increments on each in_valid. When the count reaches WARMUP, the state moves to RUN. The sample that completes the count is discarded. No samples are kept in this state.
  - RUN: on each in_valid, a sample is kept if phase==0. Phase advances 0..DECIM-1 and wraps to 0. Phase is 0 on entry to RUN, so the first post-warm-up sample is always kept.
- in_valid low: no counter or phase change and no pipeline write. No input backpressure exists; the FIR streams continuously.
- Stage 1 (registered), round half-up:
  - r = in_data + 2^(SHIFT-1), computed in IN_W+1 bits with no wrap.
  - Then arithmetic shift right by SHIFT.
- Stage 2 (registered), saturation:
  - Results above 2^(OUT_W-1)-1 are clamped to 0x7FFF.
  - Results below -2^(OUT_W-1) are clamped to 0x8000.
  - Any clamp sets sat_flag.
- FIFO write occurs at the end of the cycle after stage 2.
  - Latency: kept in_valid in cycle N, then out_valid=1 in cycle N+3 when the FIFO was empty and no overflow occurs.
- FIFO behaviour:
  - No fall-through: a pushed word becomes visible the cycle after the write.
  - Pop occurs when out_valid && out_ready.
  - out_data and out_valid stay stable while out_valid && !out_ready.
- Full FIFO:
  - A push with no pop in the same cycle drops the new sample; FIFO contents are unchanged; ovf_flag sets.
  - A push and pop in the same cycle when full are both performed; nothing is dropped and the level is unchanged.
- Empty FIFO: out_valid=0; out_ready is ignored.
- fifo_level equals pushes minus pops and never exceeds FIFO_DEPTH.
- Flags:
  - sat_flag and ovf_flag are sticky until clear_flags.
  - If clear_flags coincides with a new set event, set wins (the flag stays 1).
- Pointer wrap-around is modulo FIFO_DEPTH; full/empty are distinguished by the extra pointer bit.

Test Plan:
1. Warm-up discard: reset, WARMUP=20, DECIM=1, continuous in_valid with in_data = 0x0000_8000 × index. Samples 0..19 produce nothing. The first out_data is round(20×0x8000 / 2^15) = 20, and out_valid rises exactly 3 cycles after input 20.
2. Rounding and saturation (DECIM=1, WARMUP=0), out_ready=1:
   - 0x0000_4000 -> 1
   - 0xFFFF_C000 -> 0
   - 0xFFFF_BFFF -> 0xFFFF
   - 0x4000_0000 -> 0x7FFF, sat_flag=1
   - 0x8000_0000 -> 0x8000
3. Decimation: DECIM=3, WARMUP=0, inputs k×0x8000 for k=0..8 -> outputs 0, 3, 6 only. Dropping in_valid for 5 cycles mid-stream does not change which samples are kept.
4. Backpressure and overflow: FIFO_DEPTH=8, DECIM=1, out_ready=0, 10 kept inputs.
   - fifo_level saturates at 8; ovf_flag=1; out_data holds the first sample throughout.
   - Release out_ready: the first 8 samples emerge in order; samples 9 and 10 are absent.
5. Full with simultaneous push/pop: fill to 8, then drive out_ready=1 while streaming. Level stays 8, ovf_flag stays 0, and data order is preserved.
6. Flags and reset: assert clear_flags in the same cycle a saturating sample reaches stage 2 -> sat_flag remains 1. Pulse clear_flags alone -> both flags 0. Assert reset with 5 words queued -> next cycle out_valid=0, fifo_level=0, and the state machine re-runs warm-up.
